// File: rtl/rcastudioii_pkg.sv
// rtl/rcastudioii_pkg.sv - shared types and constants for the RCA Studio II cartridge loader
package rcastudioii_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SNIFF,
    S_REPLAY,
    S_RAW,
    S_ST2HDR,
    S_ST2DATA,
    S_FINISH
  } ld_state_t;

  // "RCA2", file byte 0 in the top byte
  localparam logic [31:0] ST2_MAGIC   = 32'h52434132;
  localparam logic [13:0] MAP_START   = 14'h0040;
  localparam logic [13:0] MAP_END     = 14'h007F;
  localparam logic [13:0] HDR_LEN     = 14'h0100;
  localparam int          MAP_ENTRIES = 64;

  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    magic_byte = ST2_MAGIC[31:24];
      2'd1:    magic_byte = ST2_MAGIC[23:16];
      2'd2:    magic_byte = ST2_MAGIC[15:8];
      default: magic_byte = ST2_MAGIC[7:0];
    endcase
  endfunction

  // Pages that hold cartridge ROM; 08/09 are system RAM and never loadable
  function automatic logic is_cart_page(input logic [7:0] page);
    case (page)
      8'h04, 8'h05, 8'h06, 8'h07,
      8'h0A, 8'h0B, 8'h0E, 8'h0F: is_cart_page = 1'b1;
      default:                    is_cart_page = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/st2_page_map.sv
// rtl/st2_page_map.sv - 64-entry block-to-page map, entry = {valid, page nibble}
module st2_page_map
  import rcastudioii_pkg::*;
(
  input  logic       clk_sys,
  input  logic       clear,
  input  logic       we,
  input  logic [5:0] waddr,
  input  logic [4:0] wdata,
  input  logic [5:0] raddr,
  output logic [4:0] rdata
);

  logic [4:0] map_mem [MAP_ENTRIES];

  always_ff @(posedge clk_sys) begin
    if (clear) begin
      for (int i = 0; i < MAP_ENTRIES; i++) map_mem[i] <= '0;
    end else if (we) begin
      map_mem[waddr] <= wdata;
    end
  end

  assign rdata = map_mem[raddr];

endmodule

// File: rtl/st2_cart_loader.sv
// rtl/st2_cart_loader.sv - routes BIOS, raw and ST2 cartridge downloads into system dpram
module st2_cart_loader
  import rcastudioii_pkg::*;
#(
  parameter logic [11:0] CART_BASE = 12'h400,
  parameter logic [11:0] IMG_LIMIT = 12'h400
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_dout,
  output logic        mem_wr,
  output logic        busy,
  output logic        cart_st2,
  output logic        load_err,
  output logic        done
);

  ld_state_t   state, state_nxt;
  logic        dl_q;
  logic        rise;
  logic        strobe;
  logic [13:0] offset;
  logic [7:0]  sniff_buf [4];
  logic [2:0]  buf_cnt;
  logic [2:0]  rep_idx;
  logic [2:0]  rep_len;
  logic [11:0] base;

  logic        start;
  logic        wr_en_nxt;
  logic [11:0] wr_addr_nxt;
  logic [7:0]  wr_data_nxt;
  logic        err_set;
  logic        st2_set;
  logic        buf_we;
  logic        rep_start;
  logic [2:0]  rep_len_nxt;
  logic        rep_adv;
  logic [11:0] base_nxt;
  logic        map_we;
  logic [5:0]  blk;
  logic        blk_oob;
  logic [4:0]  map_rdata;

  assign rise       = ioctl_download & ~dl_q;
  assign strobe     = ioctl_wr & ~ioctl_wait;
  assign offset     = ioctl_addr[13:0];
  assign blk        = offset[13:8] - 6'd1;
  assign blk_oob    = (ioctl_addr[24:8] > 17'd64) || (ioctl_addr[24:8] == 17'd0);
  assign ioctl_wait = (state == S_REPLAY);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_FINISH);

  st2_page_map u_page_map (
    .clk_sys (clk_sys),
    .clear   (reset | start),
    .we      (map_we),
    .waddr   (offset[5:0]),
    .wdata   ({is_cart_page(ioctl_dout), ioctl_dout[3:0]}),
    .raddr   (blk),
    .rdata   (map_rdata)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start       = 1'b0;
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = mem_addr;
    wr_data_nxt = mem_dout;
    err_set     = 1'b0;
    st2_set     = 1'b0;
    buf_we      = 1'b0;
    rep_start   = 1'b0;
    rep_len_nxt = rep_len;
    rep_adv     = 1'b0;
    base_nxt    = base;
    map_we      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (rise) begin
          start = 1'b1;
          if (ioctl_index == 8'd0) begin
            state_nxt = S_RAW;
            base_nxt  = 12'h000;
          end else begin
            state_nxt = S_SNIFF;
            base_nxt  = CART_BASE;
          end
        end
      end
      S_SNIFF: begin
        if (!ioctl_download) begin
          if (buf_cnt == 3'd0) begin
            state_nxt = S_FINISH;
          end else begin
            state_nxt   = S_REPLAY;
            rep_start   = 1'b1;
            rep_len_nxt = buf_cnt;
          end
        end else if (strobe) begin
          buf_we = 1'b1;
          if (ioctl_dout != magic_byte(buf_cnt[1:0])) begin
            state_nxt   = S_REPLAY;
            rep_start   = 1'b1;
            rep_len_nxt = buf_cnt + 3'd1;
          end else if (buf_cnt == 3'd3) begin
            state_nxt = S_ST2HDR;
            st2_set   = 1'b1;
          end
        end
      end
      S_REPLAY: begin
        // Always drain through RAW so the last replay write never lands in FINISH
        wr_en_nxt   = 1'b1;
        wr_addr_nxt = base + {9'd0, rep_idx};
        wr_data_nxt = sniff_buf[rep_idx[1:0]];
        rep_adv     = 1'b1;
        if (rep_idx + 3'd1 == rep_len) state_nxt = S_RAW;
      end
      S_RAW: begin
        if (!ioctl_download) begin
          state_nxt = S_FINISH;
        end else if (strobe) begin
          if (ioctl_addr >= {13'd0, IMG_LIMIT}) begin
            err_set = 1'b1;
          end else begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = base + ioctl_addr[11:0];
            wr_data_nxt = ioctl_dout;
          end
        end
      end
      S_ST2HDR: begin
        if (!ioctl_download) begin
          state_nxt = S_FINISH;
        end else if (strobe) begin
          map_we = (offset >= MAP_START) && (offset <= MAP_END);
          if (offset == HDR_LEN - 14'd1) state_nxt = S_ST2DATA;
        end
      end
      S_ST2DATA: begin
        if (!ioctl_download) begin
          state_nxt = S_FINISH;
        end else if (strobe) begin
          if (!blk_oob && map_rdata[4]) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = {map_rdata[3:0], offset[7:0]};
            wr_data_nxt = ioctl_dout;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Reset leaves dl_q high so a download still asserted across reset is not restarted
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_q     <= 1'b1;
      mem_wr   <= 1'b0;
      mem_addr <= '0;
      mem_dout <= '0;
      cart_st2 <= 1'b0;
      load_err <= 1'b0;
      buf_cnt  <= '0;
      rep_idx  <= '0;
      rep_len  <= '0;
      base     <= '0;
    end else begin
      dl_q     <= ioctl_download;
      mem_wr   <= wr_en_nxt;
      mem_addr <= wr_addr_nxt;
      mem_dout <= wr_data_nxt;
      base     <= base_nxt;
      if (start) begin
        cart_st2 <= 1'b0;
        load_err <= 1'b0;
        buf_cnt  <= '0;
      end else begin
        if (st2_set) cart_st2 <= 1'b1;
        if (err_set) load_err <= 1'b1;
        if (buf_we)  buf_cnt  <= buf_cnt + 3'd1;
      end
      if (rep_start) begin
        rep_idx <= '0;
        rep_len <= rep_len_nxt;
      end else if (rep_adv) begin
        rep_idx <= rep_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (buf_we) sniff_buf[buf_cnt[1:0]] <= ioctl_dout;
  end

endmodule

// File: tb/tb_st2_cart_loader.sv
// tb/tb_st2_cart_loader.sv - directed self-checking bench for st2_cart_loader
module tb_st2_cart_loader;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [11:0] mem_addr;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic        busy, cart_st2, load_err, done;

  int checks = 0;
  int failures = 0;
  int wr_count = 0;
  int wait_cycles = 0;
  int done_count = 0;
  logic [7:0] shadow [4096];

  st2_cart_loader dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .mem_addr       (mem_addr),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .busy           (busy),
    .cart_st2       (cart_st2),
    .load_err       (load_err),
    .done           (done)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (mem_wr) begin
      shadow[mem_addr] = mem_dout;
      wr_count++;
    end
    if (ioctl_wait) wait_cycles++;
    if (done) done_count++;
  end

  task automatic clear_counts();
    wr_count = 0;
    wait_cycles = 0;
    done_count = 0;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    @(posedge clk_sys); #1;
    ioctl_index = idx;
    ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
  endtask

  task automatic end_dl();
    @(posedge clk_sys); #1;
    ioctl_download = 1'b0;
    repeat (8) @(posedge clk_sys);
    #1;
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    int n;
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
    n = 0;
    while (ioctl_wait && n < 20) begin
      @(posedge clk_sys); #1;
      n++;
    end
    if (n >= 20) begin
      checks++; failures++;
      $display("FAIL wait_timeout: ioctl_wait still high after %0d cycles, required low", n);
    end
  endtask

  function automatic logic [7:0] dat(input int n);
    dat = 8'(n + (n >> 8) * 8'h11);
  endfunction

  task automatic send_st2_header(input logic [7:0] p0, input logic [7:0] p1);
    logic [7:0] b;
    send_byte(25'h0, 8'h52);
    send_byte(25'h1, 8'h43);
    send_byte(25'h2, 8'h41);
    send_byte(25'h3, 8'h32);
    for (int n = 4; n < 256; n++) begin
      b = (n == 'h40) ? p0 : (n == 'h41) ? p1 : 8'h00;
      send_byte(25'(n), b);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ioctl_download = 1'b0; ioctl_index = 8'h00; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0;
    repeat (3) @(posedge clk_sys);
    #1;
    checks++; if (mem_wr !== 1'b0)     begin failures++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr); end
    checks++; if (ioctl_wait !== 1'b0) begin failures++; $display("FAIL reset_wait: got %b want 0", ioctl_wait); end
    checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)       begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (cart_st2 !== 1'b0)   begin failures++; $display("FAIL reset_cart_st2: got %b want 0", cart_st2); end
    checks++; if (load_err !== 1'b0)   begin failures++; $display("FAIL reset_load_err: got %b want 0", load_err); end
    checks++; if (mem_addr !== 12'h0)  begin failures++; $display("FAIL reset_mem_addr: got %h want 000", mem_addr); end
    checks++; if (mem_dout !== 8'h0)   begin failures++; $display("FAIL reset_mem_dout: got %h want 00", mem_dout); end
    reset = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
  endtask

  task automatic test_bios();
    clear_counts();
    start_dl(8'h00);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bios_busy: got %b want 1", busy); end
    send_byte(25'h0, 8'hAA);
    send_byte(25'h1, 8'hBB);
    send_byte(25'h2, 8'hCC);
    send_byte(25'h3, 8'hDD);
    end_dl();
    checks++; if (shadow[12'h000] !== 8'hAA) begin failures++; $display("FAIL bios_000: got %h want AA", shadow[12'h000]); end
    checks++; if (shadow[12'h003] !== 8'hDD) begin failures++; $display("FAIL bios_003: got %h want DD", shadow[12'h003]); end
    checks++; if (wr_count !== 4)      begin failures++; $display("FAIL bios_writes: got %0d want 4", wr_count); end
    checks++; if (wait_cycles !== 0)   begin failures++; $display("FAIL bios_wait: got %0d want 0", wait_cycles); end
    checks++; if (cart_st2 !== 1'b0)   begin failures++; $display("FAIL bios_cart_st2: got %b want 0", cart_st2); end
    checks++; if (done_count !== 1)    begin failures++; $display("FAIL bios_done: got %0d want 1", done_count); end
    checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL bios_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_raw_cart();
    clear_counts();
    start_dl(8'h01);
    send_byte(25'h0, 8'h12);
    send_byte(25'h1, 8'h34);
    send_byte(25'h2, 8'h56);
    end_dl();
    checks++; if (wait_cycles !== 1)         begin failures++; $display("FAIL raw_wait: got %0d want 1", wait_cycles); end
    checks++; if (shadow[12'h400] !== 8'h12) begin failures++; $display("FAIL raw_400: got %h want 12", shadow[12'h400]); end
    checks++; if (shadow[12'h401] !== 8'h34) begin failures++; $display("FAIL raw_401: got %h want 34", shadow[12'h401]); end
    checks++; if (shadow[12'h402] !== 8'h56) begin failures++; $display("FAIL raw_402: got %h want 56", shadow[12'h402]); end
    checks++; if (wr_count !== 3)            begin failures++; $display("FAIL raw_writes: got %0d want 3", wr_count); end
    checks++; if (done_count !== 1)          begin failures++; $display("FAIL raw_done: got %0d want 1", done_count); end
  endtask

  task automatic test_late_mismatch();
    clear_counts();
    start_dl(8'h01);
    send_byte(25'h0, 8'h52);
    send_byte(25'h1, 8'h43);
    send_byte(25'h2, 8'h41);
    send_byte(25'h3, 8'h00);
    end_dl();
    checks++; if (wait_cycles !== 4)         begin failures++; $display("FAIL late_wait: got %0d want 4", wait_cycles); end
    checks++; if (shadow[12'h400] !== 8'h52) begin failures++; $display("FAIL late_400: got %h want 52", shadow[12'h400]); end
    checks++; if (shadow[12'h402] !== 8'h41) begin failures++; $display("FAIL late_402: got %h want 41", shadow[12'h402]); end
    checks++; if (shadow[12'h403] !== 8'h00) begin failures++; $display("FAIL late_403: got %h want 00", shadow[12'h403]); end
    checks++; if (wr_count !== 4)            begin failures++; $display("FAIL late_writes: got %0d want 4", wr_count); end
    checks++; if (cart_st2 !== 1'b0)         begin failures++; $display("FAIL late_cart_st2: got %b want 0", cart_st2); end
  endtask

  task automatic test_raw_limit();
    clear_counts();
    start_dl(8'h01);
    send_byte(25'h0, 8'h12);
    send_byte(25'h3FF, 8'hAB);
    checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL limit_err_early: got %b want 0", load_err); end
    send_byte(25'h400, 8'hCD);
    end_dl();
    checks++; if (shadow[12'h7FF] !== 8'hAB) begin failures++; $display("FAIL limit_7ff: got %h want AB", shadow[12'h7FF]); end
    checks++; if (wr_count !== 2)            begin failures++; $display("FAIL limit_writes: got %0d want 2", wr_count); end
    checks++; if (load_err !== 1'b1)         begin failures++; $display("FAIL limit_err: got %b want 1", load_err); end
  endtask

  task automatic test_st2_image();
    clear_counts();
    start_dl(8'h01);
    send_st2_header(8'h04, 8'h0A);
    checks++; if (wr_count !== 0)    begin failures++; $display("FAIL st2_hdr_writes: got %0d want 0", wr_count); end
    checks++; if (cart_st2 !== 1'b1) begin failures++; $display("FAIL st2_flag_hdr: got %b want 1", cart_st2); end
    for (int n = 'h100; n < 'h300; n++) send_byte(25'(n), dat(n));
    end_dl();
    checks++; if (shadow[12'h400] !== 8'h11) begin failures++; $display("FAIL st2_400: got %h want 11", shadow[12'h400]); end
    checks++; if (shadow[12'h4FF] !== 8'h10) begin failures++; $display("FAIL st2_4ff: got %h want 10", shadow[12'h4FF]); end
    checks++; if (shadow[12'hA00] !== 8'h22) begin failures++; $display("FAIL st2_a00: got %h want 22", shadow[12'hA00]); end
    checks++; if (shadow[12'hAFF] !== 8'h21) begin failures++; $display("FAIL st2_aff: got %h want 21", shadow[12'hAFF]); end
    checks++; if (wr_count !== 512)  begin failures++; $display("FAIL st2_writes: got %0d want 512", wr_count); end
    checks++; if (cart_st2 !== 1'b1) begin failures++; $display("FAIL st2_flag: got %b want 1", cart_st2); end
    checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL st2_err: got %b want 0", load_err); end
    checks++; if (done_count !== 1)  begin failures++; $display("FAIL st2_done: got %0d want 1", done_count); end
  endtask

  task automatic test_bad_page();
    clear_counts();
    start_dl(8'h02);
    send_st2_header(8'h08, 8'h00);
    for (int n = 'h100; n < 'h200; n++) send_byte(25'(n), dat(n));
    end_dl();
    checks++; if (wr_count !== 0)    begin failures++; $display("FAIL badpg_writes: got %0d want 0", wr_count); end
    checks++; if (load_err !== 1'b1) begin failures++; $display("FAIL badpg_err: got %b want 1", load_err); end
    checks++; if (cart_st2 !== 1'b1) begin failures++; $display("FAIL badpg_flag: got %b want 1", cart_st2); end
  endtask

  task automatic test_fall_in_sniff();
    clear_counts();
    start_dl(8'h01);
    send_byte(25'h0, 8'h52);
    send_byte(25'h1, 8'h43);
    shadow[12'h400] = 8'h00;
    shadow[12'h401] = 8'h00;
    end_dl();
    checks++; if (shadow[12'h400] !== 8'h52) begin failures++; $display("FAIL fall_400: got %h want 52", shadow[12'h400]); end
    checks++; if (shadow[12'h401] !== 8'h43) begin failures++; $display("FAIL fall_401: got %h want 43", shadow[12'h401]); end
    checks++; if (wr_count !== 2)   begin failures++; $display("FAIL fall_writes: got %0d want 2", wr_count); end
    checks++; if (wait_cycles !== 2) begin failures++; $display("FAIL fall_wait: got %0d want 2", wait_cycles); end
    checks++; if (done_count !== 1) begin failures++; $display("FAIL fall_done: got %0d want 1", done_count); end
  endtask

  task automatic test_reset_mid();
    clear_counts();
    start_dl(8'h01);
    send_byte(25'h0, 8'h52);
    send_byte(25'h1, 8'h43);
    reset = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;
    reset = 1'b0;
    repeat (5) @(posedge clk_sys);
    #1;
    checks++; if (wr_count !== 0)   begin failures++; $display("FAIL rstmid_writes: got %0d want 0", wr_count); end
    checks++; if (done_count !== 0) begin failures++; $display("FAIL rstmid_done: got %0d want 0", done_count); end
    checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    ioctl_download = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    clear_counts();
    start_dl(8'h01);
    send_byte(25'h0, 8'h99);
    end_dl();
    checks++; if (shadow[12'h400] !== 8'h99) begin failures++; $display("FAIL rstmid_400: got %h want 99", shadow[12'h400]); end
    checks++; if (wr_count !== 1)    begin failures++; $display("FAIL rstmid_writes2: got %0d want 1", wr_count); end
    checks++; if (done_count !== 1)  begin failures++; $display("FAIL rstmid_done2: got %0d want 1", done_count); end
    checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL rstmid_err: got %b want 0", load_err); end
  endtask

  initial begin
    test_reset();
    test_bios();
    test_raw_cart();
    test_late_mismatch();
    test_raw_limit();
    test_st2_image();
    test_bad_page();
    test_fall_in_sniff();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
